// File: rtl/robs_pkg.sv
// robs_pkg: shared state/op types and counter sizing for the Robertson multiplier
package robs_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {OP_PASS, OP_ADD, OP_SUB} op_t;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/robs_addsub.sv
// robs_addsub: N-bit pass/add/subtract unit with carry-out of the add
module robs_addsub
  import robs_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  op_t          i_op,
  output logic [N-1:0] o_sum,
  output logic         o_carry
);
  logic [N-1:0] w_b;
  logic [N:0]   w_full;
  assign w_b = (i_op == OP_SUB) ? ~i_b : (i_op == OP_ADD) ? i_b : '0;
  assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{N{1'b0}}, i_op == OP_SUB};
  assign o_sum = w_full[N-1:0];
  assign o_carry = w_full[N];
endmodule

// File: rtl/robs_mult_param.sv
// robs_mult_param: sequential shift-add multiplier, signed (Robertson) or unsigned,
// one multiplier bit per clock with start/busy/done handshake.
module robs_mult_param
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);
  localparam int CW = cnt_w(WIDTH);
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_last;
  logic               r_sgn;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_mreg;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_ext;
  logic [WIDTH:0]     w_sum;
  logic               w_carry;
  logic               w_msb;
  op_t                w_op;
  assign w_ext = {r_sgn & r_mcand[WIDTH-1], r_mcand};
  // the final multiplier bit carries negative weight in signed mode
  assign w_op = !r_mreg[0] ? OP_PASS : (r_sgn && r_cnt == CW'(WIDTH - 1)) ? OP_SUB : OP_ADD;
  assign w_msb = r_sgn ? w_sum[WIDTH] : w_carry;
  robs_addsub #(.N(WIDTH + 1)) u_addsub (
    .i_a    (r_acc),
    .i_b    (w_ext),
    .i_op   (w_op),
    .o_sum  (w_sum),
    .o_carry(w_carry)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_sgn   <= 1'b0;
      r_acc   <= '0;
      r_mreg  <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_sgn   <= is_signed;
          r_mreg  <= multiplier;
          r_mcand <= multiplicand;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_last  <= 1'b0;
          r_state <= CALC;
        end
        // r_last marks all WIDTH steps retired; the next cycle publishes the product
        CALC: if (r_last) begin
          r_prod  <= {r_acc[WIDTH-1:0], r_mreg};
          r_state <= DONE;
        end else begin
          r_acc  <= {w_msb, w_sum[WIDTH:1]};
          r_mreg <= {w_sum[0], r_mreg[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          r_last <= (r_cnt == CW'(WIDTH - 1));
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign product = r_prod;
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
endmodule

// File: tb/tb_robs_mult_param.sv
// tb_robs_mult_param: directed and random checks of the 8- and 16-bit multiplier
module tb_robs_mult_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset;
  logic        s8, g8, bz8, d8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        s16, g16, bz16, d16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  int checks = 0;
  int errors = 0;

  robs_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8), .is_signed(g8),
    .multiplier(a8), .multiplicand(b8), .product(p8), .busy(bz8), .done(d8)
  );
  robs_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(s16), .is_signed(g16),
    .multiplier(a16), .multiplicand(b16), .product(p16), .busy(bz16), .done(d16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input bit wide, input bit sgn, input logic [15:0] a, input logic [15:0] b);
    longint x, y, p;
    x = wide ? {{48{sgn & a[15]}}, a} : {{56{sgn & a[7]}}, a[7:0]};
    y = wide ? {{48{sgn & b[15]}}, b} : {{56{sgn & b[7]}}, b[7:0]};
    p = x * y;
    return wide ? p[31:0] : {16'h0, p[15:0]};
  endfunction

  task automatic run(input bit wide, input bit sgn, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp, input string tag);
    int lat = 0;
    int lim = wide ? 17 : 9;
    @(negedge clk);
    if (wide) begin s16 = 1; g16 = sgn; a16 = a; b16 = b; end
    else begin s8 = 1; g8 = sgn; a8 = a[7:0]; b8 = b[7:0]; end
    @(posedge clk); #1;
    s8 = 0; s16 = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (wide ? d16 : d8) lat = c;
    end
    chk({tag, " latency"}, 32'(lat), 32'(lim));
    chk({tag, " product"}, wide ? p16 : {16'h0, p8}, exp);
    @(posedge clk); #1;
    chk({tag, " done width"}, {31'd0, wide ? d16 : d8}, 32'd0);
  endtask

  initial begin
    logic seen;
    logic [15:0] ra, rb;
    bit rs;
    reset = 1; s8 = 0; g8 = 0; a8 = 0; b8 = 0; s16 = 0; g16 = 0; a16 = 0; b16 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst p8", {16'h0, p8}, 32'd0);
    chk("rst busy8", {31'd0, bz8}, 32'd0);
    chk("rst done8", {31'd0, d8}, 32'd0);
    chk("rst p16", p16, 32'd0);
    chk("rst busy16", {31'd0, bz16}, 32'd0);

    run(0, 1, 16'h0080, 16'h0080, 32'h4000, "s -128*-128");
    run(0, 1, 16'h007F, 16'h0080, 32'hC080, "s 127*-128");
    run(0, 1, 16'h00FF, 16'h0001, 32'hFFFF, "s -1*1");
    run(0, 0, 16'h00FF, 16'h00FF, 32'hFE01, "u 255*255");
    run(0, 0, 16'h0000, 16'h00C8, 32'h0000, "u 0*200");
    run(0, 1, 16'h0000, 16'h0080, 32'h0000, "s 0*-128");

    // start held high, operands churning; second op captures operands seen in IDLE
    @(negedge clk);
    s8 = 1; g8 = 0; a8 = 7; b8 = 9;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      a8 = 8'(c); b8 = 8'(c + 1);
      if (c == 9) begin
        chk("hold done", {31'd0, d8}, 32'd1);
        chk("hold product", {16'h0, p8}, 32'd63);
      end else if (c == 20) begin
        chk("second done", {31'd0, d8}, 32'd1);
        chk("second product", {16'h0, p8}, 32'd110);
        s8 = 0;
      end else chk($sformatf("hold no done c%0d", c), {31'd0, d8}, 32'd0);
      if (c == 10) begin
        chk("idle busy", {31'd0, bz8}, 32'd0);
        chk("idle product held", {16'h0, p8}, 32'd63);
      end
      if (c == 11) chk("restart busy", {31'd0, bz8}, 32'd1);
    end
    @(posedge clk); #1;
    chk("hold no third done", {31'd0, d8}, 32'd0);

    // abort 3 cycles into 100*100
    @(negedge clk);
    s8 = 1; g8 = 0; a8 = 100; b8 = 100;
    @(posedge clk); #1;
    s8 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort product", {16'h0, p8}, 32'd0);
    chk("abort busy", {31'd0, bz8}, 32'd0);
    chk("abort done", {31'd0, d8}, 32'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | d8;
    end
    chk("abort no done", {31'd0, seen}, 32'd0);
    run(0, 1, 16'h0003, 16'h0005, 32'h000F, "s 3*5");

    run(1, 1, 16'h8000, 16'h0002, 32'hFFFF0000, "w16 -32768*2");
    run(1, 1, 16'h8000, 16'h8000, 32'h40000000, "w16 -32768*-32768");
    run(1, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16 u max*max");

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
      run(0, rs, ra, rb, ref_mul(0, rs, ra, rb), $sformatf("rnd8 %0d", i));
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
      run(1, rs, ra, rb, ref_mul(1, rs, ra, rb), $sformatf("rnd16 %0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
